// File: rtl/multi_cycle_control_if.sv
// Signal bundle between the multi-cycle control FSM (master) and the
// datapath / memory side (slave). Names match the datapath wiring.
interface multi_cycle_control_if #(
  parameter int ALU_OP_WIDTH = 3
);
  // Mem_Ready_i is a completion strobe, not a request/grant pair: the control
  // unit holds Mem_Read/Mem_Write, IorD and the address selects steady for
  // every cycle of an access, and the access finishes on the first cycle in
  // which memory raises Mem_Ready_i. Memory may sample on any of those cycles.
  logic [6:0]              OP_i;
  logic                    Mem_Ready_i;
  logic                    PC_Write_o;
  logic                    PC_Write_Cond_o;
  logic                    Old_PC_Write_o;
  logic                    IR_Write_o;
  logic                    IorD_o;
  logic                    Mem_Read_o;
  logic                    Mem_Write_o;
  logic                    Reg_Write_o;
  logic [1:0]              Mem_to_Reg_o;
  logic [1:0]              ALU_Src_A_o;
  logic [1:0]              ALU_Src_B_o;
  logic [ALU_OP_WIDTH-1:0] ALU_Op_o;
  logic [1:0]              PC_Src_o;
  logic                    Illegal_o;
  logic                    Bus_Error_o;
  logic [3:0]              State_o;

  modport master (
    input  OP_i, Mem_Ready_i,
    output PC_Write_o, PC_Write_Cond_o, Old_PC_Write_o, IR_Write_o, IorD_o,
           Mem_Read_o, Mem_Write_o, Reg_Write_o, Mem_to_Reg_o, ALU_Src_A_o,
           ALU_Src_B_o, ALU_Op_o, PC_Src_o, Illegal_o, Bus_Error_o, State_o
  );

  modport slave (
    output OP_i, Mem_Ready_i,
    input  PC_Write_o, PC_Write_Cond_o, Old_PC_Write_o, IR_Write_o, IorD_o,
           Mem_Read_o, Mem_Write_o, Reg_Write_o, Mem_to_Reg_o, ALU_Src_A_o,
           ALU_Src_B_o, ALU_Op_o, PC_Src_o, Illegal_o, Bus_Error_o, State_o
  );
endinterface

// File: rtl/multi_cycle_control.sv
// Multi-cycle RISC-V control unit: sequences fetch/decode/execute/memory/
// write-back over a shared memory port with wait-state timeout and trapping.
module multi_cycle_control #(
  parameter int ALU_OP_WIDTH = 3,
  parameter int MEM_TIMEOUT  = 16,
  parameter int TRAP_EN      = 1
) (
  input logic                   clk,
  input logic                   reset,
  multi_cycle_control_if.master bus
);
  typedef enum logic [3:0] {
    S_FETCH = 4'd0, S_DECODE = 4'd1, S_EXEC_R = 4'd2, S_EXEC_I = 4'd3,
    S_EXEC_LUI = 4'd4, S_MEM_ADDR = 4'd5, S_MEM_READ = 4'd6, S_MEM_WB = 4'd7,
    S_MEM_WRITE = 4'd8, S_ALU_WB = 4'd9, S_BRANCH = 4'd10, S_JAL = 4'd11,
    S_JALR = 4'd12, S_TRAP = 4'd13
  } state_t;

  localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_illegal;
  logic          r_bus_err;

  logic w_wait_state, w_waiting, w_timeout;

  assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEM_READ) ||
                        (r_state == S_MEM_WRITE);
  assign w_waiting    = w_wait_state && !bus.Mem_Ready_i;
  // The limit check uses the pre-increment count, so the cycle that would
  // bring the count to MEM_TIMEOUT is the last one; ready on it still wins.
  assign w_timeout    = (MEM_TIMEOUT > 0) && w_waiting && (r_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_cnt     <= '0;
      r_illegal <= 1'b0;
      r_bus_err <= 1'b0;
    end else begin
      r_cnt <= '0;
      if (w_waiting && !w_timeout && (MEM_TIMEOUT > 0)) r_cnt <= r_cnt + 1'b1;
      case (r_state)
        S_FETCH:     if (bus.Mem_Ready_i) r_state <= S_DECODE;
        S_DECODE: begin
          case (bus.OP_i)
            7'h33:        r_state <= S_EXEC_R;
            7'h13:        r_state <= S_EXEC_I;
            7'h37:        r_state <= S_EXEC_LUI;
            7'h03, 7'h23: r_state <= S_MEM_ADDR;
            7'h63:        r_state <= S_BRANCH;
            7'h6F:        r_state <= S_JAL;
            7'h67:        r_state <= S_JALR;
            default: begin
              if (TRAP_EN != 0) begin
                r_state   <= S_TRAP;
                r_illegal <= 1'b1;
              end else begin
                r_state <= S_FETCH;
              end
            end
          endcase
        end
        S_EXEC_R, S_EXEC_I, S_EXEC_LUI: r_state <= S_ALU_WB;
        S_MEM_ADDR:  r_state <= (bus.OP_i == 7'h23) ? S_MEM_WRITE : S_MEM_READ;
        S_MEM_READ:  if (bus.Mem_Ready_i) r_state <= S_MEM_WB;
        S_MEM_WRITE: if (bus.Mem_Ready_i) r_state <= S_FETCH;
        S_MEM_WB, S_ALU_WB, S_BRANCH, S_JAL, S_JALR: r_state <= S_FETCH;
        S_TRAP:      r_state <= S_TRAP;
        default: begin
          r_state   <= S_TRAP;
          r_illegal <= 1'b1;
        end
      endcase
      if (w_timeout) begin
        if (TRAP_EN != 0) begin
          r_state   <= S_TRAP;
          r_bus_err <= 1'b1;
        end else begin
          r_state <= S_FETCH;
        end
      end
    end
  end

  logic       w_pc_write, w_pc_write_cond, w_old_pc_write, w_ir_write;
  logic       w_iord, w_mem_read, w_mem_write, w_reg_write;
  logic [1:0] w_mem_to_reg, w_src_a, w_src_b, w_pc_src;
  logic [2:0] w_alu_op;

  // Moore decode of the state; reset blanks everything, including the
  // ready-qualified fetch strobes.
  always_comb begin
    w_pc_write      = 1'b0;
    w_pc_write_cond = 1'b0;
    w_old_pc_write  = 1'b0;
    w_ir_write      = 1'b0;
    w_iord          = 1'b0;
    w_mem_read      = 1'b0;
    w_mem_write     = 1'b0;
    w_reg_write     = 1'b0;
    w_mem_to_reg    = 2'b00;
    w_src_a         = 2'b00;
    w_src_b         = 2'b00;
    w_alu_op        = 3'b000;
    w_pc_src        = 2'b00;
    if (!reset) begin
      case (r_state)
        S_FETCH: begin
          w_mem_read = 1'b1;
          w_src_b    = 2'b01;
          w_alu_op   = 3'b100;
          if (bus.Mem_Ready_i) begin
            w_ir_write     = 1'b1;
            w_pc_write     = 1'b1;
            w_old_pc_write = 1'b1;
          end
        end
        S_DECODE:    begin w_src_a = 2'b10; w_src_b = 2'b10; w_alu_op = 3'b100; end
        S_EXEC_R:    begin w_src_a = 2'b01; w_src_b = 2'b00; w_alu_op = 3'b000; end
        S_EXEC_I:    begin w_src_a = 2'b01; w_src_b = 2'b10; w_alu_op = 3'b001; end
        S_EXEC_LUI:  begin w_src_b = 2'b10; w_alu_op = 3'b010; end
        S_MEM_ADDR: begin
          w_src_a  = 2'b01;
          w_src_b  = 2'b10;
          w_alu_op = (bus.OP_i == 7'h23) ? 3'b011 : 3'b100;
        end
        S_MEM_READ:  begin w_mem_read = 1'b1; w_iord = 1'b1; end
        S_MEM_WB:    begin w_reg_write = 1'b1; w_mem_to_reg = 2'b01; end
        S_MEM_WRITE: begin w_mem_write = 1'b1; w_iord = 1'b1; end
        S_ALU_WB:    w_reg_write = 1'b1;
        S_BRANCH: begin
          w_src_a = 2'b01; w_alu_op = 3'b111; w_pc_write_cond = 1'b1; w_pc_src = 2'b01;
        end
        S_JAL: begin
          w_alu_op = 3'b101; w_pc_write = 1'b1; w_pc_src = 2'b01;
          w_reg_write = 1'b1; w_mem_to_reg = 2'b10;
        end
        S_JALR: begin
          w_src_a = 2'b01; w_src_b = 2'b10; w_alu_op = 3'b110; w_pc_write = 1'b1;
          w_reg_write = 1'b1; w_mem_to_reg = 2'b10;
        end
        default: ;
      endcase
    end
  end

  assign bus.PC_Write_o      = w_pc_write;
  assign bus.PC_Write_Cond_o = w_pc_write_cond;
  assign bus.Old_PC_Write_o  = w_old_pc_write;
  assign bus.IR_Write_o      = w_ir_write;
  assign bus.IorD_o          = w_iord;
  assign bus.Mem_Read_o      = w_mem_read;
  assign bus.Mem_Write_o     = w_mem_write;
  assign bus.Reg_Write_o     = w_reg_write;
  assign bus.Mem_to_Reg_o    = w_mem_to_reg;
  assign bus.ALU_Src_A_o     = w_src_a;
  assign bus.ALU_Src_B_o     = w_src_b;
  assign bus.ALU_Op_o        = ALU_OP_WIDTH'(w_alu_op);
  assign bus.PC_Src_o        = w_pc_src;
  assign bus.Illegal_o       = r_illegal & ~reset;
  assign bus.Bus_Error_o     = r_bus_err & ~reset;
  assign bus.State_o         = reset ? 4'd0 : r_state;
endmodule

// File: tb/tb_multi_cycle_control.sv
// Bench for multi_cycle_control: two instances (trapping and non-trapping,
// both with a 4-cycle memory timeout) driven in lockstep from directed vectors.
module tb_multi_cycle_control;
  localparam int W = 25;
  // Vector layout: {state[4], pcw, pcwc, opcw, irw, iord, mrd, mwr, rgw,
  //                 mem_to_reg[2], src_a[2], src_b[2], alu_op[3], pc_src[2], ill, berr}
  localparam logic [W-1:0] E_ZERO     = '0;
  localparam logic [W-1:0] E_F_RDY    = {4'd0,  8'b1011_0100, 2'b00, 2'b00, 2'b01, 3'b100, 2'b00, 2'b00};
  localparam logic [W-1:0] E_F_WAIT   = {4'd0,  8'b0000_0100, 2'b00, 2'b00, 2'b01, 3'b100, 2'b00, 2'b00};
  localparam logic [W-1:0] E_DEC      = {4'd1,  8'b0000_0000, 2'b00, 2'b10, 2'b10, 3'b100, 2'b00, 2'b00};
  localparam logic [W-1:0] E_EXR      = {4'd2,  8'b0000_0000, 2'b00, 2'b01, 2'b00, 3'b000, 2'b00, 2'b00};
  localparam logic [W-1:0] E_EXI      = {4'd3,  8'b0000_0000, 2'b00, 2'b01, 2'b10, 3'b001, 2'b00, 2'b00};
  localparam logic [W-1:0] E_LUI      = {4'd4,  8'b0000_0000, 2'b00, 2'b00, 2'b10, 3'b010, 2'b00, 2'b00};
  localparam logic [W-1:0] E_MA_LW    = {4'd5,  8'b0000_0000, 2'b00, 2'b01, 2'b10, 3'b100, 2'b00, 2'b00};
  localparam logic [W-1:0] E_MA_SW    = {4'd5,  8'b0000_0000, 2'b00, 2'b01, 2'b10, 3'b011, 2'b00, 2'b00};
  localparam logic [W-1:0] E_MRD      = {4'd6,  8'b0000_1100, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 2'b00};
  localparam logic [W-1:0] E_MWB      = {4'd7,  8'b0000_0001, 2'b01, 2'b00, 2'b00, 3'b000, 2'b00, 2'b00};
  localparam logic [W-1:0] E_MWR      = {4'd8,  8'b0000_1010, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 2'b00};
  localparam logic [W-1:0] E_AWB      = {4'd9,  8'b0000_0001, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 2'b00};
  localparam logic [W-1:0] E_BR       = {4'd10, 8'b0100_0000, 2'b00, 2'b01, 2'b00, 3'b111, 2'b01, 2'b00};
  localparam logic [W-1:0] E_JAL      = {4'd11, 8'b1000_0001, 2'b10, 2'b00, 2'b00, 3'b101, 2'b01, 2'b00};
  localparam logic [W-1:0] E_JALR     = {4'd12, 8'b1000_0001, 2'b10, 2'b01, 2'b10, 3'b110, 2'b00, 2'b00};
  localparam logic [W-1:0] E_TRAP_ILL = {4'd13, 8'b0000_0000, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 2'b10};
  localparam logic [W-1:0] E_TRAP_BUS = {4'd13, 8'b0000_0000, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 2'b01};

  logic       clk;
  logic       r_rst;
  logic [6:0] r_op;
  logic       r_rdy;
  logic       obs_valid;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_b_q[$];
  int           step_q[$];
  int           n_step;
  int           total;
  int           bad;

  multi_cycle_control_if #(.ALU_OP_WIDTH(3)) if_a ();
  multi_cycle_control_if #(.ALU_OP_WIDTH(3)) if_b ();

  assign if_a.OP_i        = r_op;
  assign if_a.Mem_Ready_i = r_rdy;
  assign if_b.OP_i        = r_op;
  assign if_b.Mem_Ready_i = r_rdy;

  multi_cycle_control #(.ALU_OP_WIDTH(3), .MEM_TIMEOUT(4), .TRAP_EN(1)) dut_a (
    .clk(clk), .reset(r_rst), .bus(if_a)
  );
  multi_cycle_control #(.ALU_OP_WIDTH(3), .MEM_TIMEOUT(4), .TRAP_EN(0)) dut_b (
    .clk(clk), .reset(r_rst), .bus(if_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] got_a, got_b;
  assign got_a = {if_a.State_o, if_a.PC_Write_o, if_a.PC_Write_Cond_o, if_a.Old_PC_Write_o,
                  if_a.IR_Write_o, if_a.IorD_o, if_a.Mem_Read_o, if_a.Mem_Write_o,
                  if_a.Reg_Write_o, if_a.Mem_to_Reg_o, if_a.ALU_Src_A_o, if_a.ALU_Src_B_o,
                  if_a.ALU_Op_o, if_a.PC_Src_o, if_a.Illegal_o, if_a.Bus_Error_o};
  assign got_b = {if_b.State_o, if_b.PC_Write_o, if_b.PC_Write_Cond_o, if_b.Old_PC_Write_o,
                  if_b.IR_Write_o, if_b.IorD_o, if_b.Mem_Read_o, if_b.Mem_Write_o,
                  if_b.Reg_Write_o, if_b.Mem_to_Reg_o, if_b.ALU_Src_A_o, if_b.ALU_Src_B_o,
                  if_b.ALU_Op_o, if_b.PC_Src_o, if_b.Illegal_o, if_b.Bus_Error_o};

  // driver: one call = one clock cycle of inputs plus its expected outputs
  task automatic step2(input logic [6:0] op, input logic rdy, input logic rst,
                       input logic [W-1:0] ea, input logic [W-1:0] eb);
    @(posedge clk);
    #1;
    r_op  = op;
    r_rdy = rdy;
    r_rst = rst;
    exp_q.push_back(ea);
    exp_b_q.push_back(eb);
    step_q.push_back(n_step);
    n_step++;
    obs_valid = 1'b1;
  endtask

  task automatic step(input logic [6:0] op, input logic rdy, input logic rst,
                      input logic [W-1:0] e);
    step2(op, rdy, rst, e, e);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (obs_valid) begin
      if (exp_q.size() == 0 || exp_b_q.size() == 0 || step_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL scoreboard_underflow: got empty queue, required one entry");
      end else begin
        logic [W-1:0] ea, eb;
        int           idx;
        ea  = exp_q.pop_front();
        eb  = exp_b_q.pop_front();
        idx = step_q.pop_front();
        total++;
        if (got_a !== ea) begin
          bad++;
          $display("FAIL trap_dut step %0d: got %h required %h", idx, got_a, ea);
        end
        total++;
        if (got_b !== eb) begin
          bad++;
          $display("FAIL nop_dut step %0d: got %h required %h", idx, got_b, eb);
        end
      end
    end
  end

  initial begin
    r_rst = 1'b1; r_op = 7'h00; r_rdy = 1'b0; obs_valid = 1'b0;
    n_step = 0; total = 0; bad = 0;

    step(7'h00, 1'b1, 1'b1, E_ZERO);
    step(7'h00, 1'b1, 1'b1, E_ZERO);
    // R, I, LUI with no wait states
    step(7'h33, 1'b1, 1'b0, E_F_RDY); step(7'h33, 1'b1, 1'b0, E_DEC);
    step(7'h33, 1'b1, 1'b0, E_EXR);   step(7'h33, 1'b1, 1'b0, E_AWB);
    step(7'h13, 1'b1, 1'b0, E_F_RDY); step(7'h13, 1'b1, 1'b0, E_DEC);
    step(7'h13, 1'b1, 1'b0, E_EXI);   step(7'h13, 1'b1, 1'b0, E_AWB);
    step(7'h37, 1'b1, 1'b0, E_F_RDY); step(7'h37, 1'b1, 1'b0, E_DEC);
    step(7'h37, 1'b1, 1'b0, E_LUI);   step(7'h37, 1'b1, 1'b0, E_AWB);
    // LW with two wait cycles in MEM_READ
    step(7'h03, 1'b1, 1'b0, E_F_RDY); step(7'h03, 1'b1, 1'b0, E_DEC);
    step(7'h03, 1'b1, 1'b0, E_MA_LW); step(7'h03, 1'b0, 1'b0, E_MRD);
    step(7'h03, 1'b0, 1'b0, E_MRD);   step(7'h03, 1'b1, 1'b0, E_MRD);
    step(7'h03, 1'b1, 1'b0, E_MWB);
    // SW, BRANCH, JAL, JALR
    step(7'h23, 1'b1, 1'b0, E_F_RDY); step(7'h23, 1'b1, 1'b0, E_DEC);
    step(7'h23, 1'b1, 1'b0, E_MA_SW); step(7'h23, 1'b1, 1'b0, E_MWR);
    step(7'h63, 1'b1, 1'b0, E_F_RDY); step(7'h63, 1'b1, 1'b0, E_DEC);
    step(7'h63, 1'b1, 1'b0, E_BR);
    step(7'h6F, 1'b1, 1'b0, E_F_RDY); step(7'h6F, 1'b1, 1'b0, E_DEC);
    step(7'h6F, 1'b1, 1'b0, E_JAL);
    step(7'h67, 1'b1, 1'b0, E_F_RDY); step(7'h67, 1'b1, 1'b0, E_DEC);
    step(7'h67, 1'b1, 1'b0, E_JALR);
    // ready arrives on the 4th fetch wait cycle: completes, no error
    for (int i = 0; i < 3; i++) step(7'h33, 1'b0, 1'b0, E_F_WAIT);
    step(7'h33, 1'b1, 1'b0, E_F_RDY); step(7'h33, 1'b1, 1'b0, E_DEC);
    step(7'h33, 1'b1, 1'b0, E_EXR);   step(7'h33, 1'b1, 1'b0, E_AWB);
    // SW with reset in the second MEM_WRITE wait cycle
    step(7'h23, 1'b1, 1'b0, E_F_RDY); step(7'h23, 1'b1, 1'b0, E_DEC);
    step(7'h23, 1'b1, 1'b0, E_MA_SW); step(7'h23, 1'b0, 1'b0, E_MWR);
    step(7'h23, 1'b0, 1'b1, E_ZERO);
    // illegal opcode: sticky trap vs. NOP refetch
    step(7'h7F, 1'b1, 1'b0, E_F_RDY); step(7'h7F, 1'b1, 1'b0, E_DEC);
    for (int i = 0; i < 20; i++)
      step2(7'h7F, 1'b1, 1'b0, E_TRAP_ILL, (i % 2 == 0) ? E_F_RDY : E_DEC);
    step(7'h7F, 1'b1, 1'b1, E_ZERO);
    step(7'h33, 1'b1, 1'b0, E_F_RDY); step(7'h33, 1'b1, 1'b0, E_DEC);
    step(7'h33, 1'b1, 1'b0, E_EXR);   step(7'h33, 1'b1, 1'b0, E_AWB);
    // fetch timeout: ready stuck low
    for (int i = 0; i < 4; i++) step(7'h33, 1'b0, 1'b0, E_F_WAIT);
    for (int i = 0; i < 3; i++) step2(7'h33, 1'b0, 1'b0, E_TRAP_BUS, E_F_WAIT);
    step(7'h33, 1'b1, 1'b1, E_ZERO);
    // MEM_READ timeout
    step(7'h03, 1'b1, 1'b0, E_F_RDY); step(7'h03, 1'b1, 1'b0, E_DEC);
    step(7'h03, 1'b1, 1'b0, E_MA_LW);
    for (int i = 0; i < 4; i++) step(7'h03, 1'b0, 1'b0, E_MRD);
    step2(7'h03, 1'b1, 1'b0, E_TRAP_BUS, E_F_RDY);
    step(7'h03, 1'b1, 1'b1, E_ZERO);
    step(7'h03, 1'b1, 1'b0, E_F_RDY);

    @(posedge clk);
    #1;
    obs_valid = 1'b0;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d leftover entries, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/multi_cycle_control.md
# multi_cycle_control

Multi-cycle control unit for the RISC-V core: a Moore/Mealy state machine that sequences each instruction through fetch, decode, execute, memory and write-back cycles over a shared instruction/data memory port. It supports the same opcode set as the single-cycle control unit (R, I-logic, LUI, SW, LW, JAL, JALR, B). It adds a memory-ready handshake, a configurable bus timeout and illegal-opcode trapping. It sits between the instruction register and the multi-cycle datapath muxes and register enables.

## Interface
- `ALU_OP_WIDTH`, 3: width of `ALU_Op_o`.
- `MEM_TIMEOUT`, 16: maximum wait cycles for `Mem_Ready_i`; 0 disables the timeout.
- `TRAP_EN`, 1: 1 means illegal opcode or timeout enters sticky TRAP; 0 means an illegal opcode is a NOP and returns to FETCH.

Ports:
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `OP_i`  in  7  opcode from the instruction register (IR[6:0]).
- `Mem_Ready_i`  in  1  memory completes the current read or write this cycle.
- `PC_Write_o`  out  1  unconditional PC load.
- `PC_Write_Cond_o`  out  1  PC load qualified by the ALU branch flag.
- `Old_PC_Write_o`  out  1  capture the current PC into OldPC.
- `IR_Write_o`  out  1  instruction register load.
- `IorD_o`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `Mem_Read_o`, `Mem_Write_o`  out  1  memory strobes.
- `Reg_Write_o`  out  1  register file write.
- `Mem_to_Reg_o`  out  2  write-back select: 00 = ALUOut, 01 = MDR, 10 = PC.
- `ALU_Src_A_o`  out  2  ALU A select: 00 = PC, 01 = rs1, 10 = OldPC.
- `ALU_Src_B_o`  out  2  ALU B select: 00 = rs2, 01 = constant 4, 10 = immediate.
- `ALU_Op_o`  out  ALU_OP_WIDTH  ALU op class. Encoding:
  - 000 = R, 001 = I-logic, 010 = LUI, 011 = SW, 100 = LW/add.
  - 101 = JAL, 110 = JALR, 111 = branch.
- `PC_Src_o`  out  2  PC source: 00 = ALU result, 01 = ALUOut.
- `Illegal_o`  out  1  trap taken because of an illegal opcode.
- `Bus_Error_o`  out  1  trap taken because of a memory timeout.
- `State_o`  out  4  current state, for debug.

## Operation
- State register is 4 bits, Moore-decoded. Exception: `IR_Write_o`, `PC_Write_o` and `Old_PC_Write_o` in FETCH are additionally gated by `Mem_Ready_i`.
- Any output not listed for a state is 0.
- FETCH (0):
  - Outputs: `Mem_Read`=1, `IorD`=0, SrcA=00, SrcB=01, ALU_Op=100.
  - While `Mem_Ready_i`=1: `IR_Write`=1, `PC_Write`=1, `Old_PC_Write`=1, `PC_Src`=00 (PC becomes PC+4).
  - Next state is DECODE when ready.
- DECODE (1):
  - Outputs: SrcA=10, SrcB=10, ALU_Op=100, so ALUOut = OldPC+imm.
  - Next state by opcode:
    - 0x33 → EXEC_R; 0x13 → EXEC_I; 0x37 → EXEC_LUI.
    - 0x03 or 0x23 → MEM_ADDR; 0x63 → BRANCH; 0x6F → JAL; 0x67 → JALR.
    - Any other opcode → TRAP (`TRAP_EN`=1) or FETCH (`TRAP_EN`=0).
- EXEC_R (2): SrcA=01, SrcB=00, ALU_Op=000. Next ALU_WB.
- EXEC_I (3): SrcA=01, SrcB=10, ALU_Op=001. Next ALU_WB.
- EXEC_LUI (4): SrcB=10, ALU_Op=010. Next ALU_WB.
- MEM_ADDR (5): SrcA=01, SrcB=10, ALU_Op=011 for SW or 100 for LW. Next MEM_WRITE for SW, MEM_READ for LW.
- MEM_READ (6): `Mem_Read`=1, `IorD`=1. Next MEM_WB when ready.
- MEM_WB (7): `Reg_Write`=1, `Mem_to_Reg`=01. Next FETCH.
- MEM_WRITE (8): `Mem_Write`=1, `IorD`=1. Next FETCH when ready.
- ALU_WB (9): `Reg_Write`=1, `Mem_to_Reg`=00. Next FETCH.
- BRANCH (10): SrcA=01, SrcB=00, ALU_Op=111, `PC_Write_Cond`=1, `PC_Src`=01. Next FETCH.
- JAL (11): ALU_Op=101, `PC_Write`=1, `PC_Src`=01, `Reg_Write`=1, `Mem_to_Reg`=10. Next FETCH.
  - rd receives PC, which already holds the return address.
- JALR (12): SrcA=01, SrcB=10, ALU_Op=110, `PC_Write`=1, `PC_Src`=00, `Reg_Write`=1, `Mem_to_Reg`=10. Next FETCH.
- TRAP (13):
  - All strobes 0; `Illegal_o` or `Bus_Error_o` held at 1.
  - Sticky: left only by `reset`.
  - States 14 and 15 are unused. If entered, the next state is TRAP with `Illegal_o`=1, regardless of `TRAP_EN`.
- Wait counter:
  - Width is clog2(`MEM_TIMEOUT`+1).
  - Cleared on entry to FETCH, MEM_READ and MEM_WRITE.
  - Increments each cycle spent in one of those states with `Mem_Ready_i`=0.
  - When it reaches `MEM_TIMEOUT` with ready still 0:
    - `TRAP_EN`=1: next state TRAP, `Bus_Error_o` set.
    - `TRAP_EN`=0: next state FETCH.
  - Ready arriving in the same cycle as the count reaches the limit takes priority: the access completes normally.

## Timing
- Reset:
  - Takes effect on the rising edge with `reset`=1.
  - While `reset` is high, all outputs are forced to 0, and this overrides the FETCH strobes.
  - After reset: state = FETCH, `Illegal_o` = `Bus_Error_o` = 0, counter = 0.
  - Reset in any state, including mid-wait or TRAP, aborts the instruction with no further strobes.
- Memory strobes, `IorD` and the address selects stay stable for every cycle of a wait. The memory may sample on any of those cycles.
- Latency with zero wait states:
  - R, I, LUI: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - BRANCH, JAL, JALR: 3 cycles.
  - Each wait cycle adds 1 cycle per memory access.
- `OP_i` is sampled only in DECODE and MEM_ADDR, when IR is stable.

## Test plan
- Reset, then `OP_i`=0x33 with `Mem_Ready_i`=1 held → `State_o` sequence 0,1,2,9,0. `IR_Write_o`=1 only in cycle 1; `Reg_Write_o`=1 only in cycle 4.
- `OP_i`=0x03; ready low for 2 cycles in MEM_READ → states 0,1,5,6,6,6,7,0. `Mem_Read_o`=1 and `IorD_o`=1 in all three MEM_READ cycles; `ALU_Op_o`=100 in MEM_ADDR.
- `OP_i`=0x63 → states 0,1,10,0. `PC_Write_Cond_o`=1, `ALU_Op_o`=111, `PC_Src_o`=01 in state 10. `OP_i`=0x6F → state 11 with `Mem_to_Reg_o`=10.
- `OP_i`=0x7F with `TRAP_EN`=1 → state 13 and `Illegal_o`=1 held for 20 cycles. Then `reset` → state 0, `Illegal_o`=0. The same opcode with `TRAP_EN`=0 → states 0,1,0.
- `MEM_TIMEOUT`=4, `Mem_Ready_i` stuck at 0 in FETCH → TRAP after 4 wait cycles with `Bus_Error_o`=1. Ready asserted on the 4th wait cycle → DECODE, no error.
- `OP_i`=0x23 with `reset` asserted in the second MEM_WRITE wait cycle → `Mem_Write_o`=0 that cycle; next state FETCH.
